id_decode_stage: RTL and testbench
==================================

Name: id_decode_stage

Overview:
- IF→ID pipeline stage for the RV32I core.
- Accepts fetched instructions over a valid/ready handshake and classifies the opcode into the team's 3-bit immType encoding.
- Generates the extended immediate and registers all results for the execute stage.
- A 2-entry skid buffer keeps full throughput under downstream backpressure; flush discards in-flight instructions on redirect.

Parameters:
- PC_W, 32, width of program counter field.
- NOP_INST, 32'h0000_0013, instruction word driven on id_inst while empty or after reset/flush (addi x0,x0,0).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all buffered instructions (branch/jump redirect)
- if_valid  in  1  fetch presents instruction
- if_inst  in  32  fetched instruction word
- if_pc  in  PC_W  PC of fetched instruction
- if_ready  out  1  stage can accept this cycle
- id_valid  out  1  decoded instruction valid
- id_ready  in  1  execute stage accepts
- id_inst  out  32  registered instruction
- id_pc  out  PC_W  registered PC
- id_immType  out  3  immType code
- id_imm  out  32  extended immediate
- id_illegal  out  1  opcode not in supported set

Behaviour:
- Reset, synchronous, priority over everything:
  - id_valid=0, skid empty, id_inst=NOP_INST, id_pc=0.
  - id_immType=3'b000, id_imm=0, id_illegal=0.
  - if_ready=1 in the cycle after reset.
- Storage: output register (OUT) plus one skid register (SKID). SKID holds the decoded instruction, not the raw word.
- if_ready = !skid_valid. This is registered state only; no combinational path from id_ready.
- Accept = if_valid & if_ready. Transfer out = id_valid & id_ready.
- Latency: an instruction accepted in cycle N appears on id_* in cycle N+1 when OUT is free or draining.
- Per clock, when not flushing:
  - OUT free (!id_valid or id_ready) and SKID valid: OUT←SKID, SKID←accepted instr if any, else SKID empty.
  - OUT free and SKID empty: OUT←accepted instr; id_valid=Accept.
  - OUT stalled (id_valid & !id_ready) and Accept: SKID←accepted instr (OUT held unchanged).
  - OUT stalled and no Accept: hold.
- Program order is always preserved. No instruction is lost or duplicated.
- flush:
  - Next cycle: id_valid=0, SKID empty, id_inst=NOP_INST, id_illegal=0.
  - Any Accept in the flush cycle is discarded.
  - flush and rst together: rst wins (same result).
- Decode on opcode inst[6:0]:
  - 0010011, 0000011, 1100111, 1110011 → 000 (I)
  - 0110011 → 001 (none)
  - 0100011 → 010 (S)
  - 1100011 → 011 (B)
  - 0110111, 0010111 → 100 (U)
  - 1101111 → 101 (J)
  - Any other opcode: id_illegal=1, immType=001, id_imm=0.
- Immediate formats:
  - I: sext(inst[31:20])
  - S: sext({inst[31:25],inst[11:7]})
  - B: sext({inst[31],inst[7],inst[30:25],inst[11:8],0})
  - U: {inst[31:12],12'h0}
  - J: sext({inst[31],inst[19:12],inst[20],inst[30:21],0})
  - none: 0
- id_* outputs are stable while id_valid & !id_ready.

Optional Feature:
- Macro ID_STALL_COUNT_EN.
- Defined:
  - Extra output port stall_cnt (out, 32): counts cycles with id_valid & !id_ready.
  - Cleared by rst only, not by flush.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then if_valid=1, if_inst=32'hFFF0_0093, id_ready=1 → next cycle id_valid=1, id_immType=000, id_imm=32'hFFFF_FFFF, id_illegal=0.
- Back-to-back stream with id_ready=1:
  - 32'hFE11_2E23 → 010, imm 32'hFFFF_FFFC
  - 32'h1234_5037 → 100, imm 32'h1234_5000
  - 32'h0080_006F → 101, imm 32'h0000_0008
  - one result per cycle; if_ready stays 1.
- Hold id_ready=0 and present three instructions with PCs 0x0, 0x4, 0x8:
  - 0x0 in OUT, 0x4 in SKID, if_ready=0; 0x8 stays held by fetch.
  - Raise id_ready → outputs 0x0, 0x4, 0x8 in consecutive cycles; stall_cnt equals stalled cycles when enabled.
- OUT and SKID full, assert flush with if_valid=1 → next cycle id_valid=0, if_ready=1, id_inst=32'h0000_0013; flushed PCs never appear.
- if_inst=32'h0000_007F → id_illegal=1, id_immType=001, id_imm=0.
- Assert rst mid-stall with both entries full → next cycle all outputs at reset values; stall_cnt=0.

Source files
------------

// File: rtl/id_decode_stage.sv
// ============================================================================
//  Module   : id_decode_stage
//  Purpose  : IF->ID stage for the RV32I core. Classifies the opcode into the
//             3-bit immType code, builds the extended immediate, and registers
//             the result behind a 2-entry (OUT + SKID) skid buffer.
//  Options  : define ID_STALL_COUNT_EN to add the stall_cnt output port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_decode_stage #(
    parameter int          PC_W     = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_ready,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_inst,
    output logic [PC_W-1:0] id_pc,
    output logic [2:0]      id_immType,
    output logic [31:0]     id_imm,
    output logic            id_illegal
`ifdef ID_STALL_COUNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;

    localparam logic [2:0] c_IMM_I    = 3'b000;
    localparam logic [2:0] c_IMM_NONE = 3'b001;
    localparam logic [2:0] c_IMM_S    = 3'b010;
    localparam logic [2:0] c_IMM_B    = 3'b011;
    localparam logic [2:0] c_IMM_U    = 3'b100;
    localparam logic [2:0] c_IMM_J    = 3'b101;

    // Decode of the incoming fetch word
    logic [2:0]  w_dec_type;
    logic [31:0] w_dec_imm;
    logic        w_dec_illegal;

    // Output register (OUT)
    logic            r_out_valid;
    logic [31:0]     r_out_inst;
    logic [PC_W-1:0] r_out_pc;
    logic [2:0]      r_out_type;
    logic [31:0]     r_out_imm;
    logic            r_out_illegal;

    // Skid register (SKID) holds an already decoded instruction
    logic            r_skid_valid;
    logic [31:0]     r_skid_inst;
    logic [PC_W-1:0] r_skid_pc;
    logic [2:0]      r_skid_type;
    logic [31:0]     r_skid_imm;
    logic            r_skid_illegal;

    logic w_accept;
    logic w_out_free;

    assign if_ready   = !r_skid_valid;
    assign w_accept   = if_valid & !r_skid_valid;
    assign w_out_free = !r_out_valid | id_ready;

    always_comb begin
        w_dec_type    = c_IMM_NONE;
        w_dec_imm     = 32'h0;
        w_dec_illegal = 1'b0;
        case (if_inst[6:0])
            c_OPC_OP_IMM, c_OPC_LOAD, c_OPC_JALR, c_OPC_SYSTEM: begin
                w_dec_type = c_IMM_I;
                w_dec_imm  = {{20{if_inst[31]}}, if_inst[31:20]};
            end
            c_OPC_OP: begin
                w_dec_type = c_IMM_NONE;
            end
            c_OPC_STORE: begin
                w_dec_type = c_IMM_S;
                w_dec_imm  = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
            end
            c_OPC_BRANCH: begin
                w_dec_type = c_IMM_B;
                w_dec_imm  = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                              if_inst[30:25], if_inst[11:8], 1'b0};
            end
            c_OPC_LUI, c_OPC_AUIPC: begin
                w_dec_type = c_IMM_U;
                w_dec_imm  = {if_inst[31:12], 12'h000};
            end
            c_OPC_JAL: begin
                w_dec_type = c_IMM_J;
                w_dec_imm  = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                              if_inst[20], if_inst[30:21], 1'b0};
            end
            default: begin
                w_dec_illegal = 1'b1;
            end
        endcase
    end

    // Flush leaves the stage exactly as reset does (stall counter excepted)
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_out_valid   <= 1'b0;
            r_out_inst    <= NOP_INST;
            r_out_pc      <= '0;
            r_out_type    <= c_IMM_I;
            r_out_imm     <= 32'h0;
            r_out_illegal <= 1'b0;
            r_skid_valid  <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_valid   <= 1'b1;
                r_out_inst    <= r_skid_inst;
                r_out_pc      <= r_skid_pc;
                r_out_type    <= r_skid_type;
                r_out_imm     <= r_skid_imm;
                r_out_illegal <= r_skid_illegal;
                r_skid_valid  <= 1'b0;
            end else if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_out_inst    <= if_inst;
                r_out_pc      <= if_pc;
                r_out_type    <= w_dec_type;
                r_out_imm     <= w_dec_imm;
                r_out_illegal <= w_dec_illegal;
            end else begin
                r_out_valid   <= 1'b0;
                r_out_inst    <= NOP_INST;
                r_out_pc      <= '0;
                r_out_type    <= c_IMM_I;
                r_out_imm     <= 32'h0;
                r_out_illegal <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
        end
    end

    // SKID payload only matters while r_skid_valid is set, so it needs no reset
    always_ff @(posedge clk) begin
        if (!w_out_free && w_accept) begin
            r_skid_inst    <= if_inst;
            r_skid_pc      <= if_pc;
            r_skid_type    <= w_dec_type;
            r_skid_imm     <= w_dec_imm;
            r_skid_illegal <= w_dec_illegal;
        end
    end

    assign id_valid   = r_out_valid;
    assign id_inst    = r_out_inst;
    assign id_pc      = r_out_pc;
    assign id_immType = r_out_type;
    assign id_imm     = r_out_imm;
    assign id_illegal = r_out_illegal;

`ifdef ID_STALL_COUNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'h0;
        end else if (r_out_valid && !id_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: a 2-deep in-order queue model of the stage plus
// directed vectors with literal expectations.
`default_nettype none

module tb_id_decode_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_inst = 32'h0;
    logic [31:0] if_pc = 32'h0;
    logic        if_ready;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [2:0]  id_immType;
    logic [31:0] id_imm;
    logic        id_illegal;
`ifdef ID_STALL_COUNT_EN
    logic [31:0] stall_cnt;
`endif

    id_decode_stage #(.PC_W(32), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_ready(if_ready),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
        .id_immType(id_immType), .id_imm(id_imm), .id_illegal(id_illegal)
`ifdef ID_STALL_COUNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written straight from the opcode table
    function automatic void ref_dec(input logic [31:0] i, output logic [2:0] t,
                                    output logic [31:0] imm, output logic ill);
        logic [6:0] op;
        op  = i[6:0];
        t   = 3'b001;
        imm = 32'h0;
        ill = 1'b0;
        if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73) begin
            t = 3'b000; imm = 32'($signed(i[31:20]));
        end else if (op == 7'h33) begin
            t = 3'b001;
        end else if (op == 7'h23) begin
            t = 3'b010; imm = 32'($signed({i[31:25], i[11:7]}));
        end else if (op == 7'h63) begin
            t = 3'b011; imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        end else if (op == 7'h37 || op == 7'h17) begin
            t = 3'b100; imm = {i[31:12], 12'h000};
        end else if (op == 7'h6F) begin
            t = 3'b101; imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        end else begin
            ill = 1'b1;
        end
    endfunction

    // Model: in-order queue of accepted {inst, pc}, capacity 2
    logic [63:0] mq[$];
    logic [31:0] mcnt = 32'h0;
    bit          model_ok = 1'b0;

    initial begin
        bit acc;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                mcnt = 32'h0;
                model_ok = 1'b1;
            end else begin
                if (mq.size() > 0 && !id_ready && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
                acc = if_valid && (mq.size() < 2);
                if (flush) mq.delete();
                else begin
                    if (mq.size() > 0 && id_ready) void'(mq.pop_front());
                    if (acc) mq.push_back({if_inst, if_pc});
                end
            end
        end
    end

    // Per-cycle compare against the model
    initial begin
        logic [2:0]  t;
        logic [31:0] imm;
        logic        ill;
        forever begin
            @(negedge clk);
            if (model_ok) begin
                chk("id_valid", 32'(id_valid), 32'(mq.size() > 0));
                chk("if_ready", 32'(if_ready), 32'(mq.size() < 2));
                if (mq.size() > 0) begin
                    ref_dec(mq[0][63:32], t, imm, ill);
                    chk("id_inst", id_inst, mq[0][63:32]);
                    chk("id_pc", id_pc, mq[0][31:0]);
                    chk("id_immType", 32'(id_immType), 32'(t));
                    chk("id_imm", id_imm, imm);
                    chk("id_illegal", 32'(id_illegal), 32'(ill));
                end else begin
                    chk("empty_inst", id_inst, NOP);
                    chk("empty_illegal", 32'(id_illegal), 32'h0);
                end
`ifdef ID_STALL_COUNT_EN
                chk("stall_cnt", stall_cnt, mcnt);
`endif
            end
        end
    end

    task automatic present(input logic [31:0] inst, input logic [31:0] pc);
        @(negedge clk);
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = pc;
    endtask

    task automatic idle();
        @(negedge clk);
        if_valid = 1'b0;
    endtask

    initial begin
        logic [2:0]  t;
        logic [31:0] imm;
        logic        ill;
        int          n;

        // Pin the reference decode with hand-computed values
        ref_dec(32'hFFF0_0093, t, imm, ill);
        chk("ref_I", {t, imm[28:0]}, {3'b000, 29'h1FFF_FFFF});
        ref_dec(32'hFE11_2E23, t, imm, ill);
        chk("ref_S", imm, 32'hFFFF_FFFC);
        ref_dec(32'h1234_5037, t, imm, ill);
        chk("ref_U", imm, 32'h1234_5000);
        ref_dec(32'h0080_006F, t, imm, ill);
        chk("ref_J", {29'(imm), t}, {29'h8, 3'b101});
        ref_dec(32'h0000_007F, t, imm, ill);
        chk("ref_ill", {28'(imm), ill, t}, {28'h0, 1'b1, 3'b001});

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(id_valid), 32'h0);
        chk("rst_inst", id_inst, NOP);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_type", 32'(id_immType), 32'h0);
        chk("rst_imm", id_imm, 32'h0);
        chk("rst_ready", 32'(if_ready), 32'h1);

        // First instruction, one-cycle latency
        if_valid = 1'b1; if_inst = 32'hFFF0_0093; if_pc = 32'h100; id_ready = 1'b1;
        idle();
        chk("first_valid", 32'(id_valid), 32'h1);
        chk("first_type", 32'(id_immType), 32'h0);
        chk("first_imm", id_imm, 32'hFFFF_FFFF);
        chk("first_ill", 32'(id_illegal), 32'h0);

        // Back-to-back stream
        present(32'hFE11_2E23, 32'h104);
        present(32'h1234_5037, 32'h108);
        chk("stream_ready", 32'(if_ready), 32'h1);
        chk("stream_S_imm", id_imm, 32'hFFFF_FFFC);
        present(32'h0080_006F, 32'h10C);
        chk("stream_U_imm", id_imm, 32'h1234_5000);
        idle();
        chk("stream_J_type", 32'(id_immType), 32'h5);
        chk("stream_J_imm", id_imm, 32'h0000_0008);
        repeat (2) @(negedge clk);

        // Backpressure: three instructions into a 2-entry stage
        id_ready = 1'b0;
        if_valid = 1'b1; if_inst = 32'h0000_0033; if_pc = 32'h0;
        present(32'h00A0_0113, 32'h4);
        present(32'h0041_2183, 32'h8);
        chk("stall_ready", 32'(if_ready), 32'h0);
        chk("stall_pc", id_pc, 32'h0);
        repeat (3) @(negedge clk);
        chk("stall_hold_pc", id_pc, 32'h0);
        id_ready = 1'b1;
        n = 0;
        while (!if_ready && n < 10) begin @(negedge clk); n++; end
        chk("drain_timeout", 32'(n < 10), 32'h1);
        chk("drain_pc4", id_pc, 32'h4);
        idle();
        chk("drain_pc8", id_pc, 32'h8);
        repeat (2) @(negedge clk);

        // Flush with both entries full and fetch presenting
        id_ready = 1'b0;
        if_valid = 1'b1; if_inst = 32'h0010_0093; if_pc = 32'h200;
        present(32'h0020_0093, 32'h204);
        @(negedge clk);
        if_inst = 32'h0030_0093; if_pc = 32'h208; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; if_valid = 1'b0;
        chk("flush_valid", 32'(id_valid), 32'h0);
        chk("flush_ready", 32'(if_ready), 32'h1);
        chk("flush_inst", id_inst, NOP);
        id_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("flush_gone", 32'(id_valid), 32'h0);

        // Illegal opcode
        present(32'h0000_007F, 32'h300);
        idle();
        chk("ill_flag", 32'(id_illegal), 32'h1);
        chk("ill_type", 32'(id_immType), 32'h1);
        chk("ill_imm", id_imm, 32'h0);
        @(negedge clk);

        // Reset mid-stall
        id_ready = 1'b0;
        if_valid = 1'b1; if_inst = 32'hFE11_2E23; if_pc = 32'h400;
        present(32'h1234_5037, 32'h404);
        @(negedge clk);
        rst = 1'b1; if_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_valid", 32'(id_valid), 32'h0);
        chk("rst2_ready", 32'(if_ready), 32'h1);
        chk("rst2_inst", id_inst, NOP);
        chk("rst2_pc", id_pc, 32'h0);
        chk("rst2_imm", id_imm, 32'h0);
        chk("rst2_ill", 32'(id_illegal), 32'h0);
`ifdef ID_STALL_COUNT_EN
        chk("rst2_stall_cnt", stall_cnt, 32'h0);
`endif
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
